// File: rtl/mmio_arb_pkg.sv
// -----------------------------------------------------------------------------
// mmio_arb_pkg
//
// Shared definitions for the two-master FPro MMIO bus arbiter.
//   - default address/data widths of the FPro MMIO bus
//   - FSM state encoding (IDLE -> ISSUE -> RESP)
//   - master index type (0 = MCS I/O bridge, 1 = secondary master)
//   - rr_pick(): round-robin choice between two requesters
//
// The optional arbitration lock is built when MMIO_ARB_LOCK_EN is defined.
// -----------------------------------------------------------------------------
package mmio_arb_pkg;

   localparam int MMIO_ADDR_WIDTH = 21;
   localparam int MMIO_DATA_WIDTH = 32;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_RESP  = 2'd2;

   typedef logic master_idx_t;

   // A lone requester wins outright; on a tie the master that was not
   // granted last wins.
   function automatic master_idx_t rr_pick(input logic        req0,
                                           input logic        req1,
                                           input master_idx_t last);
      if (req0 && req1) begin
         return ~last;
      end else if (req1) begin
         return 1'b1;
      end
      return 1'b0;
   endfunction

endpackage

// File: rtl/mmio_arb_rr_sel.sv
// -----------------------------------------------------------------------------
// mmio_arb_rr_sel
//
// Round-robin grant selector for two masters. Holds the index of the last
// master served (and, with MMIO_ARB_LOCK_EN, the lock owner) and turns the
// two request levels into a grant index plus a valid flag.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req0_i, req1_i    request levels of master 0 / master 1
//   commit_i          strobe: the grant in commit_idx_i has been issued
//   commit_idx_i      master whose transaction is being issued
//   commit_lock_i     lock flag latched with that transaction (MMIO_ARB_LOCK_EN)
//   grant_idx_o       selected master
//   grant_valid_o     at least one eligible request is present
// -----------------------------------------------------------------------------
module mmio_arb_rr_sel
   import mmio_arb_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req0_i,
   input  logic req1_i,
   input  logic commit_i,
   input  logic commit_idx_i,
`ifdef MMIO_ARB_LOCK_EN
   input  logic commit_lock_i,
`endif
   output logic grant_idx_o,
   output logic grant_valid_o
);

   master_idx_t last_grant_q, last_grant_d;
   logic        req0_eff, req1_eff;

`ifdef MMIO_ARB_LOCK_EN
   logic        lock_q, lock_d;
   master_idx_t lock_owner_q, lock_owner_d;
`endif

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the block leaves it unassigned and no latch is inferred.
      req0_eff = req0_i;
      req1_eff = req1_i;
`ifdef MMIO_ARB_LOCK_EN
      // While locked only the owner's request is visible; the other stalls.
      if (lock_q) begin
         if (lock_owner_q) req0_eff = 1'b0;
         else              req1_eff = 1'b0;
      end
`endif
      grant_valid_o = req0_eff | req1_eff;
      grant_idx_o   = rr_pick(req0_eff, req1_eff, last_grant_q);
   end

   always_comb begin
      last_grant_d = last_grant_q;
`ifdef MMIO_ARB_LOCK_EN
      lock_d       = lock_q;
      lock_owner_d = lock_owner_q;
`endif
      if (commit_i) begin
         last_grant_d = commit_idx_i;
`ifdef MMIO_ARB_LOCK_EN
         // Only the owner can be issued while locked, so the committed lock
         // flag both takes and releases the lock.
         lock_d       = commit_lock_i;
         lock_owner_d = commit_idx_i;
`endif
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      if (reset) begin
         last_grant_q <= 1'b1;   // master 0 wins the first tie
`ifdef MMIO_ARB_LOCK_EN
         lock_q       <= 1'b0;
         lock_owner_q <= 1'b0;
`endif
      end else begin
         last_grant_q <= last_grant_d;
`ifdef MMIO_ARB_LOCK_EN
         lock_q       <= lock_d;
         lock_owner_q <= lock_owner_d;
`endif
      end
   end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mmio_bus_arbiter
//
// Shares one FPro MMIO bus between two masters (0: MicroBlaze MCS I/O bridge,
// 1: secondary master such as a debug loader or DMA). Requests are served
// round-robin; each one becomes a single-cycle FPro strobe followed by a
// single-cycle ack to the grantee, with read data held in a per-master
// register. Throughput is one transaction per three cycles.
//
// Build option: define MMIO_ARB_LOCK_EN to add m0_lock / m1_lock, which pin
// arbitration to a master for atomic read-modify-write sequences.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   mX_req                   request level, held until mX_ack
//   mX_write                 1 = write, 0 = read
//   mX_addr, mX_wr_data      word address / write data
//   mX_lock                  hold arbitration after this access (option)
//   mX_rd_data               registered read data, held until next read
//   mX_ack                   one-cycle completion pulse
//   mmio_cs/read/write       FPro strobes, high only in the issue cycle
//   mmio_addr, mmio_wr_data  FPro address / write data (zero when idle)
//   mmio_rd_data             FPro read data, valid during the cs cycle
// -----------------------------------------------------------------------------
module mmio_bus_arbiter
   import mmio_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = MMIO_ADDR_WIDTH,
   parameter int DATA_WIDTH = MMIO_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_req,
   input  logic                  m0_write,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wr_data,
`ifdef MMIO_ARB_LOCK_EN
   input  logic                  m0_lock,
`endif
   output logic [DATA_WIDTH-1:0] m0_rd_data,
   output logic                  m0_ack,
   input  logic                  m1_req,
   input  logic                  m1_write,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wr_data,
`ifdef MMIO_ARB_LOCK_EN
   input  logic                  m1_lock,
`endif
   output logic [DATA_WIDTH-1:0] m1_rd_data,
   output logic                  m1_ack,
   output logic                  mmio_cs,
   output logic                  mmio_read,
   output logic                  mmio_write,
   output logic [ADDR_WIDTH-1:0] mmio_addr,
   output logic [DATA_WIDTH-1:0] mmio_wr_data,
   input  logic [DATA_WIDTH-1:0] mmio_rd_data
);

   state_t                state_q, state_d;
   master_idx_t           idx_q, idx_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rd0_q, rd0_d;
   logic [DATA_WIDTH-1:0] rd1_q, rd1_d;

   master_idx_t           grant_idx;
   logic                  grant_valid;
   logic                  issue;
   logic                  resp;

`ifdef MMIO_ARB_LOCK_EN
   logic                  lock_q, lock_d;
`endif

   assign issue = (state_q == ST_ISSUE);
   assign resp  = (state_q == ST_RESP);

   // last_grant advances as the transaction is issued, so a reset during
   // ISSUE leaves it at its reset value.
   mmio_arb_rr_sel u_rr_sel (
      .clk           (clk),
      .reset         (reset),
      .req0_i        (m0_req),
      .req1_i        (m1_req),
      .commit_i      (issue),
      .commit_idx_i  (idx_q),
`ifdef MMIO_ARB_LOCK_EN
      .commit_lock_i (lock_q),
`endif
      .grant_idx_o   (grant_idx),
      .grant_valid_o (grant_valid)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd0_d   = rd0_q;
      rd1_d   = rd1_q;
`ifdef MMIO_ARB_LOCK_EN
      lock_d  = lock_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // Requests are only looked at here; changes during ISSUE/RESP
            // are picked up in the next IDLE cycle.
            if (grant_valid) begin
               idx_d   = grant_idx;
               write_d = grant_idx ? m1_write   : m0_write;
               addr_d  = grant_idx ? m1_addr    : m0_addr;
               wdata_d = grant_idx ? m1_wr_data : m0_wr_data;
`ifdef MMIO_ARB_LOCK_EN
               lock_d  = grant_idx ? m1_lock    : m0_lock;
`endif
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // The controller's read data is combinational in the cs cycle.
            if (!write_q) begin
               if (idx_q) rd1_d = mmio_rd_data;
               else       rd0_d = mmio_rd_data;
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: the transaction latches are cleared on reset too; they are few
      // and it keeps every output at a defined zero after reset.
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd0_q   <= '0;
         rd1_q   <= '0;
`ifdef MMIO_ARB_LOCK_EN
         lock_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
`ifdef MMIO_ARB_LOCK_EN
         lock_q  <= lock_d;
`endif
      end
   end

   // Bus outputs are decoded from registered state and are zero outside ISSUE.
   assign mmio_cs      = issue;
   assign mmio_read    = issue & ~write_q;
   assign mmio_write   = issue & write_q;
   assign mmio_addr    = issue ? addr_q  : '0;
   assign mmio_wr_data = issue ? wdata_q : '0;

   assign m0_ack     = resp & ~idx_q;
   assign m1_ack     = resp & idx_q;
   assign m0_rd_data = rd0_q;
   assign m1_rd_data = rd1_q;

endmodule

// File: doc/mmio_bus_arbiter.md
Name: mmio_bus_arbiter

Overview:
- Shares the single FPro MMIO bus (cs/read/write/addr/wr_data/rd_data) between two bus masters.
  - Master 0: MicroBlaze MCS I/O bridge.
  - Master 1: secondary master, e.g. a UART debug loader or DMA engine.
- Sits between the masters and the MMIO controller.
- Serialises requests with round-robin arbitration, issues one-cycle FPro transactions and returns registered read data with a one-cycle ack.

Parameters:
- ADDR_WIDTH, 21, FPro MMIO address width.
- DATA_WIDTH, 32, FPro data width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- m0_req, m1_req  input  1  request level; held until the matching ack.
- m0_write, m1_write  input  1  1 = write, 0 = read; stable while req is high.
- m0_addr, m1_addr  input  ADDR_WIDTH  word address; stable while req is high.
- m0_wr_data, m1_wr_data  input  DATA_WIDTH  write data; stable while req is high.
- m0_rd_data, m1_rd_data  output  DATA_WIDTH  registered read data; held until that master's next read.
- m0_ack, m1_ack  output  1  one-cycle completion pulse.
- mmio_cs  output  1  FPro chip select, one-cycle strobe.
- mmio_read  output  1  FPro read strobe.
- mmio_write  output  1  FPro write strobe.
- mmio_addr  output  ADDR_WIDTH  FPro address.
- mmio_wr_data  output  DATA_WIDTH  FPro write data.
- mmio_rd_data  input  DATA_WIDTH  FPro read data; combinational from the controller during the cs cycle.

Behaviour:
- **Reset (synchronous):**
  - All outputs 0; state IDLE; last_grant = 1, so m0 wins the first tie.
  - Reset mid-transaction aborts it: no ack, and mmio_cs is low in the cycle after the reset edge.
- **FSM IDLE:**
  - If no req, stay in IDLE.
  - Otherwise select the grantee:
    - Only one req high: grant that master.
    - Both high: grant the master != last_grant.
  - Latch the grantee's write/addr/wr_data and the grant index; go to ISSUE.
- **FSM ISSUE (exactly one cycle):**
  - mmio_cs = 1, mmio_read = ~write, mmio_write = write, mmio_addr / mmio_wr_data from the latches.
  - On a read, capture mmio_rd_data into the grantee's rd_data register at the end of this cycle.
  - Update last_grant; go to RESP.
- **FSM RESP (one cycle):**
  - Grantee's ack = 1; all mmio_* outputs = 0; go to IDLE.
- **Timing and throughput:**
  - Latency from req sampled high in IDLE to ack is 2 cycles.
  - One transaction per 3 cycles maximum.
- **Master rules:**
  - A master deasserts req on the edge ending its ack cycle.
  - A req still high in the following IDLE is a new request.
- **Read data:**
  - On a write, the grantee's rd_data is unchanged.
  - The non-granted master's rd_data and ack never change during another master's transaction.
- **Request changes:** a req that rises during ISSUE or RESP is only considered in the next IDLE. A req that drops outside IDLE is ignored.
- **Bus idle:** mmio_read, mmio_write and mmio_cs are never asserted outside ISSUE.
- **Width rules:** addresses and data pass through unmodified; there is no width conversion.

Optional Feature:
- Macro: MMIO_ARB_LOCK_EN.
- **Enabled:**
  - Adds inputs m0_lock and m1_lock, sampled with the request.
  - If the grantee's lock is high when its request is latched, arbitration is locked to that master: in subsequent IDLE cycles only its req is considered and the other master stalls.
  - The lock releases after a transaction from the locked master completes with lock low.
  - Reset clears the lock.
  - Used for atomic read-modify-write of slot registers.
- **Disabled:** no lock ports; pure round-robin.

Decomposition:
- **Package mmio_arb_pkg:**
  - state enum (IDLE, ISSUE, RESP).
  - master index typedef (1 bit).
  - default ADDR_WIDTH / DATA_WIDTH constants.
- **Sub-module mmio_arb_rr_sel:**
  - Holds last_grant (and the lock owner when the feature is enabled).
  - Produces the grant index and a valid signal from the two reqs.
  - Updates on a grant-commit strobe.

Test Plan:
- **Single write:** m0_req, write, addr 0x00041, wr_data 0xDEADBEEF → one cycle mmio_cs=1, mmio_write=1 with those values; m0_ack 1 cycle later; m1_ack stays 0.
- **Single read:** m1 reads addr 0x00080 while the model drives mmio_rd_data=0x12345678 in the cs cycle → m1_rd_data=0x12345678 with m1_ack 2 cycles after the req is sampled; m0_rd_data unchanged.
- **Round-robin:** both reqs held high continuously for 4 transactions → grant order m0, m1, m0, m1; a cs strobe every 3 cycles.
- **Late arrival:** m1_req rises during m0's ISSUE cycle → m0 completes; m1 is granted in the next IDLE; no cs strobe in RESP.
- **Reset in ISSUE:** assert reset during ISSUE → no ack; all outputs 0 after the edge; after release with both reqs high, m0 is granted first.
- **Lock (MMIO_ARB_LOCK_EN):** m0 locked read then unlocked write while m1_req is high → m1 is granted only after m0's write ack.
